// File: rtl/alu_pkg.sv
// Shared constants and types for the ID/EX ALU issue stage: ALUFun codes,
// MIPS opcode/funct values, the decoded-op struct and the EX payload struct.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FUN_W = 6;
  localparam int unsigned REG_W = 5;

  typedef logic [FUN_W-1:0] alu_fun_t;

  // ALUFun codes; group lives in [5:4], every compare code has bit0 set.
  localparam alu_fun_t ALU_ADD    = 6'b000000;
  localparam alu_fun_t ALU_SUB    = 6'b000001;
  localparam alu_fun_t ALU_AND    = 6'b011000;
  localparam alu_fun_t ALU_OR     = 6'b011110;
  localparam alu_fun_t ALU_XOR    = 6'b010110;
  localparam alu_fun_t ALU_NOR    = 6'b010001;
  localparam alu_fun_t ALU_PASS_A = 6'b011010;
  localparam alu_fun_t ALU_SLL    = 6'b100000;
  localparam alu_fun_t ALU_SRL    = 6'b100001;
  localparam alu_fun_t ALU_SRA    = 6'b100011;
  localparam alu_fun_t ALU_EQ     = 6'b110011;
  localparam alu_fun_t ALU_NEQ    = 6'b110001;
  localparam alu_fun_t ALU_LT     = 6'b110101;
  localparam alu_fun_t ALU_LEZ    = 6'b111101;
  localparam alu_fun_t ALU_LTZ    = 6'b111011;
  localparam alu_fun_t ALU_GTZ    = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {IN1_ZERO, IN1_RS, IN1_SHAMT, IN1_C16} in1_sel_e;
  typedef enum logic [1:0] {IN2_ZERO, IN2_RT, IN2_SIMM, IN2_ZIMM} in2_sel_e;
  typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_sel_e;

  typedef struct packed {
    alu_fun_t  fun;
    logic      sign;
    in1_sel_e  sel_in1;
    in2_sel_e  sel_in2;
    dest_sel_e dest_sel;
    logic      reg_write;
    logic      is_branch;
    logic      illegal;
  } dec_op_t;

  typedef struct packed {
    logic [XLEN-1:0]  in1;
    logic [XLEN-1:0]  in2;
    alu_fun_t         fun;
    logic             sign;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_branch;
    logic             illegal;
  } ex_payload_t;

  localparam dec_op_t DEC_ILLEGAL = '{fun: ALU_ADD, sign: 1'b0, sel_in1: IN1_ZERO,
                                      sel_in2: IN2_ZERO, dest_sel: DEST_NONE,
                                      reg_write: 1'b0, is_branch: 1'b0, illegal: 1'b1};

  // Legal op builder; writeback is implied by having a destination.
  function automatic dec_op_t dec_op(input alu_fun_t fun, input logic sign,
                                     input in1_sel_e s1, input in2_sel_e s2,
                                     input dest_sel_e d, input logic br);
    dec_op_t r;
    r.fun       = fun;
    r.sign      = sign;
    r.sel_in1   = s1;
    r.sel_in2   = s2;
    r.dest_sel  = d;
    r.reg_write = (d != DEST_NONE);
    r.is_branch = br;
    r.illegal   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: opcode/funct/rt field to ALUFun, sign mode,
// operand selects and destination select.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  output dec_op_t    dec_c
);

  always_comb begin
    dec_c = DEC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  dec_c = dec_op(ALU_ADD, 1'b1, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_ADDU: dec_c = dec_op(ALU_ADD, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SUB:  dec_c = dec_op(ALU_SUB, 1'b1, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SUBU: dec_c = dec_op(ALU_SUB, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SLT:  dec_c = dec_op(ALU_LT,  1'b1, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SLTU: dec_c = dec_op(ALU_LT,  1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_AND:  dec_c = dec_op(ALU_AND, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_OR:   dec_c = dec_op(ALU_OR,  1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_XOR:  dec_c = dec_op(ALU_XOR, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_NOR:  dec_c = dec_op(ALU_NOR, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SLL:  dec_c = dec_op(ALU_SLL, 1'b0, IN1_SHAMT, IN2_RT, DEST_RD, 1'b0);
          F_SRL:  dec_c = dec_op(ALU_SRL, 1'b0, IN1_SHAMT, IN2_RT, DEST_RD, 1'b0);
          F_SRA:  dec_c = dec_op(ALU_SRA, 1'b0, IN1_SHAMT, IN2_RT, DEST_RD, 1'b0);
          F_SLLV: dec_c = dec_op(ALU_SLL, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SRLV: dec_c = dec_op(ALU_SRL, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          F_SRAV: dec_c = dec_op(ALU_SRA, 1'b0, IN1_RS,    IN2_RT, DEST_RD, 1'b0);
          default: dec_c = DEC_ILLEGAL;
        endcase
      end
      // Only bltz is supported in the REGIMM space.
      OP_REGIMM: begin
        if (rt_field == 5'd0)
          dec_c = dec_op(ALU_LTZ, 1'b1, IN1_RS, IN2_ZERO, DEST_NONE, 1'b1);
      end
      OP_BEQ:   dec_c = dec_op(ALU_EQ,  1'b0, IN1_RS,  IN2_RT,   DEST_NONE, 1'b1);
      OP_BNE:   dec_c = dec_op(ALU_NEQ, 1'b0, IN1_RS,  IN2_RT,   DEST_NONE, 1'b1);
      OP_BLEZ:  dec_c = dec_op(ALU_LEZ, 1'b1, IN1_RS,  IN2_ZERO, DEST_NONE, 1'b1);
      OP_BGTZ:  dec_c = dec_op(ALU_GTZ, 1'b1, IN1_RS,  IN2_ZERO, DEST_NONE, 1'b1);
      OP_ADDI:  dec_c = dec_op(ALU_ADD, 1'b1, IN1_RS,  IN2_SIMM, DEST_RT,   1'b0);
      OP_ADDIU: dec_c = dec_op(ALU_ADD, 1'b0, IN1_RS,  IN2_SIMM, DEST_RT,   1'b0);
      OP_SLTI:  dec_c = dec_op(ALU_LT,  1'b1, IN1_RS,  IN2_SIMM, DEST_RT,   1'b0);
      OP_SLTIU: dec_c = dec_op(ALU_LT,  1'b0, IN1_RS,  IN2_SIMM, DEST_RT,   1'b0);
      OP_ANDI:  dec_c = dec_op(ALU_AND, 1'b0, IN1_RS,  IN2_ZIMM, DEST_RT,   1'b0);
      OP_ORI:   dec_c = dec_op(ALU_OR,  1'b0, IN1_RS,  IN2_ZIMM, DEST_RT,   1'b0);
      OP_XORI:  dec_c = dec_op(ALU_XOR, 1'b0, IN1_RS,  IN2_ZIMM, DEST_RT,   1'b0);
      OP_LUI:   dec_c = dec_op(ALU_SLL, 1'b0, IN1_C16, IN2_ZIMM, DEST_RT,   1'b0);
      OP_LW:    dec_c = dec_op(ALU_ADD, 1'b0, IN1_RS,  IN2_SIMM, DEST_RT,   1'b0);
      OP_SW:    dec_c = dec_op(ALU_ADD, 1'b0, IN1_RS,  IN2_SIMM, DEST_NONE, 1'b0);
      default:  dec_c = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction, muxes/extends operands and
// holds them in a valid/ready pipeline register that feeds the shared ALU.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW                  = 32,
  parameter bit          FLUSH_CLEARS_FIELDS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       instr,
  input  logic [DW-1:0]     rs_data,
  input  logic [DW-1:0]     rt_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DW-1:0]     alu_in1,
  output logic [DW-1:0]     alu_in2,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              alu_sign,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_branch,
  output logic              ex_illegal
);

  dec_op_t     dec;
  ex_payload_t ex_d, ex_q;
  logic        valid_q;
  logic        load_c;
  logic [4:0]  dest_c;
  logic        unused_rs_field;

  // rs arrives already forwarded in rs_data, so the rs field itself is not needed.
  assign unused_rs_field = ^instr[25:21];

  alu_op_decode u_decode (
    .opcode   (instr[31:26]),
    .funct    (instr[5:0]),
    .rt_field (instr[20:16]),
    .dec_c    (dec)
  );

  always_comb begin
    ex_d   = '0;
    dest_c = 5'd0;
    case (dec.sel_in1)
      IN1_RS:    ex_d.in1 = rs_data;
      IN1_SHAMT: ex_d.in1 = DW'(instr[10:6]);
      IN1_C16:   ex_d.in1 = DW'(16);
      default:   ex_d.in1 = '0;
    endcase
    case (dec.sel_in2)
      IN2_RT:   ex_d.in2 = rt_data;
      IN2_SIMM: ex_d.in2 = {{(DW-16){instr[15]}}, instr[15:0]};
      IN2_ZIMM: ex_d.in2 = DW'(instr[15:0]);
      default:  ex_d.in2 = '0;
    endcase
    case (dec.dest_sel)
      DEST_RD: dest_c = instr[15:11];
      DEST_RT: dest_c = instr[20:16];
      default: dest_c = 5'd0;
    endcase
    ex_d.fun       = dec.fun;
    ex_d.sign      = dec.sign;
    ex_d.rd        = dest_c;
    ex_d.reg_write = dec.reg_write & (dest_c != 5'd0);
    ex_d.is_branch = dec.is_branch;
    ex_d.illegal   = dec.illegal;
  end

  assign id_ready = ~valid_q | ex_ready;
  assign load_c   = id_valid & id_ready & ~flush;

  // Pipeline register: reset > flush > load > consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      if (FLUSH_CLEARS_FIELDS) ex_q <= '0;
    end else if (load_c) begin
      valid_q <= 1'b1;
      ex_q    <= ex_d;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid     = valid_q;
  assign alu_in1      = ex_q.in1;
  assign alu_in2      = ex_q.in2;
  assign alu_fun      = ex_q.fun;
  assign alu_sign     = ex_q.sign;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode of representative
// instructions, stall hold, flush priority and back-to-back issue.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_branch;
  logic        ex_illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_fun      (alu_fun),
    .alu_sign     (alu_sign),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_branch (ex_is_branch),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  // Packed view: {valid, fun, sign, in1, in2, rd, reg_write, is_branch, illegal}
  function automatic logic [79:0] exp_v(input logic v, input logic [5:0] f,
                                        input logic s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] rd,
                                        input logic wr, input logic br, input logic ill);
    return {v, f, s, a, b, rd, wr, br, ill};
  endfunction

  function automatic logic [79:0] snap();
    return {ex_valid, alu_fun, alu_sign, alu_in1, alu_in2, ex_rd,
            ex_reg_write, ex_is_branch, ex_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [79:0] e;
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    step();
    step();
    reset = 1'b0;
    instr = 32'h0022_1822; rs_data = 32'd5; rt_data = 32'd7; id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    #1;
    total++;
    if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_setup_stall: valid=%b ready=%b want valid=1 ready=0", ex_valid, id_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    e = exp_v(1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL reset_clear: got %h want %h", snap(), e);
    end
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
  endtask

  task automatic test_sub();
    logic [79:0] e;
    instr = 32'h0022_1822; rs_data = 32'd5; rt_data = 32'd7;
    id_valid = 1'b1; ex_ready = 1'b1;
    step();
    id_valid = 1'b0;
    e = exp_v(1'b1, 6'b000001, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL sub_issue: got %h want %h", snap(), e);
    end
    step();
    total++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      bad++;
      $display("FAIL consume_empty: valid=%b ready=%b want valid=0 ready=1", ex_valid, id_ready);
    end
  endtask

  task automatic test_lui_sra();
    logic [79:0] e;
    ex_ready = 1'b1; id_valid = 1'b1;
    instr = 32'h3C04_1234; rs_data = 32'hAAAA_5555; rt_data = 32'h1;
    step();
    e = exp_v(1'b1, 6'b100000, 1'b0, 32'd16, 32'h0000_1234, 5'd4, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL lui_issue: got %h want %h", snap(), e);
    end
    instr = 32'h0005_10C3; rs_data = 32'h0000_DEAD; rt_data = 32'h8000_0000;
    step();
    id_valid = 1'b0;
    e = exp_v(1'b1, 6'b100011, 1'b0, 32'd3, 32'h8000_0000, 5'd2, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL sra_issue: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_stall();
    logic [79:0] e;
    logic [79:0] e2;
    ex_ready = 1'b1; id_valid = 1'b1;
    instr = 32'h28E6_FFFF; rs_data = 32'h11; rt_data = 32'h22;
    step();
    e = exp_v(1'b1, 6'b110101, 1'b1, 32'h11, 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL slti_issue: got %h want %h", snap(), e);
    end
    instr = 32'h012A_4021; rs_data = 32'h100; rt_data = 32'h200; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (snap() !== e) begin
        bad++;
        $display("FAIL stall_hold_%0d: got %h want %h", i, snap(), e);
      end
      total++;
      if (id_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready_%0d: got %b want 0", i, id_ready);
      end
    end
    ex_ready = 1'b1;
    step();
    id_valid = 1'b0;
    e2 = exp_v(1'b1, 6'b000000, 1'b0, 32'h100, 32'h200, 5'd8, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== e2) begin
      bad++;
      $display("FAIL stall_release: got %h want %h", snap(), e2);
    end
  endtask

  task automatic test_flush();
    logic [79:0] e;
    ex_ready = 1'b1; id_valid = 1'b1; flush = 1'b1;
    instr = 32'h3405_8001; rs_data = 32'h0; rt_data = 32'h99;
    step();
    flush = 1'b0; id_valid = 1'b0;
    e = exp_v(1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL flush_beats_load: got %h want %h", snap(), e);
    end
    step();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_dropped: valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5];
    logic [31:0] rsv [5];
    logic [31:0] rtv [5];
    logic [79:0] ev  [5];
    ins[0] = 32'h1022_0010; rsv[0] = 32'h10;        rtv[0] = 32'h20;
    ev[0]  = exp_v(1'b1, 6'b110011, 1'b0, 32'h10, 32'h20, 5'd0, 1'b0, 1'b1, 1'b0);
    ins[1] = 32'h0460_0008; rsv[1] = 32'hFFFF_FFF0; rtv[1] = 32'h55;
    ev[1]  = exp_v(1'b1, 6'b111011, 1'b1, 32'hFFFF_FFF0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    ins[2] = 32'h3405_8001; rsv[2] = 32'h0;         rtv[2] = 32'h99;
    ev[2]  = exp_v(1'b1, 6'b011110, 1'b0, 32'h0, 32'h0000_8001, 5'd5, 1'b1, 1'b0, 1'b0);
    ins[3] = 32'h2000_0005; rsv[3] = 32'h3;         rtv[3] = 32'h4;
    ev[3]  = exp_v(1'b1, 6'b000000, 1'b1, 32'h3, 32'h5, 5'd0, 1'b0, 1'b0, 1'b0);
    ins[4] = 32'h8C22_FFFC; rsv[4] = 32'h1000;      rtv[4] = 32'h7;
    ev[4]  = exp_v(1'b1, 6'b000000, 1'b0, 32'h1000, 32'hFFFF_FFFC, 5'd2, 1'b1, 1'b0, 1'b0);
    ex_ready = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr = ins[i]; rs_data = rsv[i]; rt_data = rtv[i];
      step();
      total++;
      if (snap() !== ev[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got %h want %h", i, snap(), ev[i]);
      end
    end
    id_valid = 1'b0;
    step();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_illegal_nop();
    logic [79:0] e;
    ex_ready = 1'b1; id_valid = 1'b1;
    instr = 32'hFC00_0000; rs_data = 32'h1; rt_data = 32'h2;
    step();
    e = exp_v(1'b1, 6'b000000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL illegal_op3f: got %h want %h", snap(), e);
    end
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    step();
    id_valid = 1'b0;
    e = exp_v(1'b1, 6'b100000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (snap() !== e) begin
      bad++;
      $display("FAIL nop_issue: got %h want %h", snap(), e);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_lui_sra();
    test_stall();
    test_flush();
    test_back_to_back();
    test_illegal_nop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
